// File: rtl/collision_pkg.sv
// Shared types for the per-frame collision scanner: hitbox layout and scan FSM states.
package collision_pkg;

    localparam int COORD_W = 10;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
    } hitbox_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN
    } scan_state_t;

endpackage

// File: rtl/collision_scanner_aabb_overlap.sv
// Strict axis-aligned overlap of the inset player box against one obstacle box.
module aabb_overlap
    import collision_pkg::*;
#(
    parameter int INSET = 2
) (
    input  hitbox_t player,
    input  hitbox_t obj,
    output logic    overlap
);

    localparam int EW = COORD_W + 1;
    localparam logic [EW-1:0] INSET_E = EW'(INSET);
    localparam logic [EW-1:0] TRIM_E  = EW'(2 * INSET);

    logic [EW-1:0] pl, pr, pt, pb;
    logic [EW-1:0] ol, orr, ot, ob;
    logic          p_wide, p_tall, o_sized;

    // One extra bit keeps right/bottom edges near the screen limit from wrapping to 0.
    always_comb begin
        pl      = {1'b0, player.x} + INSET_E;
        pr      = {1'b0, player.x} + {1'b0, player.w} - INSET_E;
        pt      = {1'b0, player.y} + INSET_E;
        pb      = {1'b0, player.y} + {1'b0, player.h} - INSET_E;
        ol      = {1'b0, obj.x};
        orr     = {1'b0, obj.x} + {1'b0, obj.w};
        ot      = {1'b0, obj.y};
        ob      = {1'b0, obj.y} + {1'b0, obj.h};
        p_wide  = {1'b0, player.w} > TRIM_E;
        p_tall  = {1'b0, player.h} > TRIM_E;
        o_sized = (obj.w != '0) && (obj.h != '0);
        overlap = p_wide && p_tall && o_sized &&
                  (pl < orr) && (pr > ol) && (pt < ob) && (pb > ot);
    end

endmodule

// File: rtl/collision_scanner.sv
// Once-per-frame scan of the player hitbox against every obstacle slot of the object table.
module collision_scanner
    import collision_pkg::*;
#(
    parameter int N_OBJ = 8,
    parameter int INSET = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [COORD_W-1:0]         px,
    input  logic [COORD_W-1:0]         py,
    input  logic [COORD_W-1:0]         pw,
    input  logic [COORD_W-1:0]         ph,
    output logic [$clog2(N_OBJ)-1:0]   obj_addr,
    input  logic                       obj_valid,
    input  logic [COORD_W-1:0]         ox,
    input  logic [COORD_W-1:0]         oy,
    input  logic [COORD_W-1:0]         ow,
    input  logic [COORD_W-1:0]         oh,
    output logic                       busy,
    output logic                       done,
    output logic                       hit,
    output logic [$clog2(N_OBJ)-1:0]   hit_idx,
    output logic [N_OBJ-1:0]           hit_mask,
    output logic                       hit_rise
);

    localparam int AW = $clog2(N_OBJ);
    localparam logic [AW-1:0] LAST = AW'(N_OBJ - 1);

    scan_state_t    state, state_nxt;
    hitbox_t        player_q, obj_box;
    logic [N_OBJ-1:0] scan_mask, pend_mask;
    logic           commit_q, cmp_en, overlap, slot_hit;
    logic [AW-1:0]  cmp_idx, prio_idx;

    always_comb begin
        obj_box  = '{x: ox, y: oy, w: ow, h: oh};
        slot_hit = overlap && obj_valid;
    end

    aabb_overlap #(.INSET(INSET)) u_overlap (
        .player  (player_q),
        .obj     (obj_box),
        .overlap (overlap)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SCAN;
            S_SCAN:  if (obj_addr == LAST) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Table data lags the address by a cycle, so the slot under test is always addr-1.
    always_comb begin
        busy    = (state != S_IDLE);
        cmp_en  = ((state == S_SCAN) && (obj_addr != '0)) || (state == S_DRAIN);
        cmp_idx = (state == S_DRAIN) ? LAST : obj_addr - AW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            obj_addr  <= '0;
            player_q  <= '0;
            scan_mask <= '0;
            pend_mask <= '0;
            commit_q  <= 1'b0;
        end else begin
            commit_q <= (state == S_DRAIN);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        player_q  <= '{x: px, y: py, w: pw, h: ph};
                        obj_addr  <= '0;
                        scan_mask <= '0;
                    end
                end
                S_SCAN: begin
                    if (obj_addr != LAST) obj_addr <= obj_addr + AW'(1);
                end
                default: ;
            endcase
            if (cmp_en) scan_mask[cmp_idx] <= slot_hit;
            // Final mask is staged so a back-to-back Start cannot disturb it before commit.
            if (state == S_DRAIN) begin
                pend_mask          <= scan_mask;
                pend_mask[N_OBJ-1] <= slot_hit;
            end
        end
    end

    always_comb begin
        prio_idx = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (pend_mask[i]) prio_idx = AW'(i);
        end
    end

    // Results and Done change on the same edge; hit doubles as the previous-scan flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            done     <= 1'b0;
            hit      <= 1'b0;
            hit_idx  <= '0;
            hit_mask <= '0;
            hit_rise <= 1'b0;
        end else begin
            done     <= commit_q;
            hit_rise <= 1'b0;
            if (commit_q) begin
                hit_mask <= pend_mask;
                hit      <= |pend_mask;
                hit_idx  <= prio_idx;
                hit_rise <= (|pend_mask) && !hit;
            end
        end
    end

endmodule
